// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC, issues icache requests,
// applies prioritised redirects and flags misaligned targets.
module pc_gen #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_ADDR = 64'h8000_0000,
  parameter int unsigned     NUM_REDIR  = 3,
  parameter int unsigned     STEP       = 4,
  parameter int unsigned     ALIGN      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  output logic                      fetch_valid_o,
  input  logic                      fetch_ready_i,
  output logic [XLEN-1:0]           fetch_addr_o,
  output logic [XLEN-1:0]           pc_o,
  output logic [NUM_REDIR-1:0]      redir_taken_o,
  output logic                      misalign_o,
  output logic [XLEN-1:0]           misalign_pc_o
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN - 1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  state_t                 state_q;
  state_t                 state_d;
  logic [XLEN-1:0]        fetch_pc_q;
  logic [NUM_REDIR-1:0]   sel_oh;
  logic [XLEN-1:0]        sel_pc;
  logic                   any_redir;
  logic                   sel_misalign;
  logic                   handshake;

  // state register; BOOT is entered only through reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // BOOT holds for one cycle, RUN is sticky
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // request is withdrawn while stalled or while the PC is being steered
  always_comb begin
    fetch_valid_o = 1'b0;
    if (state_q == RUN)
      fetch_valid_o = ~stall_i & ~flush_i & ~any_redir;
  end

  // lowest asserted channel wins; scan from the top so it overrides
  always_comb begin
    sel_oh = '0;
    sel_pc = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_pc    = redir_pc_i[i*XLEN +: XLEN];
      end
    end
  end

  assign any_redir     = |redir_valid_i;
  assign sel_misalign  = |(sel_pc & ALIGN_MASK);
  assign redir_taken_o = flush_i ? '0 : sel_oh;
  assign handshake     = fetch_valid_o & fetch_ready_i;
  assign fetch_addr_o  = fetch_pc_q;

  // fetch PC, committed PC and misalign report
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_ADDR;
      pc_o          <= RESET_ADDR;
      misalign_o    <= 1'b0;
      misalign_pc_o <= '0;
    end else begin
      misalign_o <= 1'b0;
      if (flush_i) begin
        fetch_pc_q <= RESET_ADDR;
      end else if (any_redir) begin
        if (sel_misalign) begin
          misalign_o    <= 1'b1;
          misalign_pc_o <= sel_pc;
        end else begin
          fetch_pc_q <= sel_pc;
        end
      end else if (handshake) begin
        pc_o       <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + STEP_INC;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen.
// Expected values are hand-computed from the block's behaviour.
module tb_pc_gen;

  localparam int XLEN = 64;
  localparam int NR   = 3;
  localparam logic [63:0] RA = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i;
  logic              flush_i;
  logic [NR-1:0]     redir_valid_i;
  logic [NR*XLEN-1:0] redir_pc_i;
  logic              fetch_valid_o;
  logic              fetch_ready_i;
  logic [XLEN-1:0]   fetch_addr_o;
  logic [XLEN-1:0]   pc_o;
  logic [NR-1:0]     redir_taken_o;
  logic              misalign_o;
  logic [XLEN-1:0]   misalign_pc_o;

  int total = 0;
  int bad   = 0;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redir_valid_i (redir_valid_i),
    .redir_pc_i    (redir_pc_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_addr_o  (fetch_addr_o),
    .pc_o          (pc_o),
    .redir_taken_o (redir_taken_o),
    .misalign_o    (misalign_o),
    .misalign_pc_o (misalign_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic redir(input logic [NR-1:0] v,
                       input logic [63:0] p0,
                       input logic [63:0] p1,
                       input logic [63:0] p2);
    redir_valid_i = v;
    redir_pc_i    = {p2, p1, p0};
  endtask

  initial begin
    rst           = 1'b1;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    fetch_ready_i = 1'b1;
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    tick();
    tick();
    chk("rst_addr", fetch_addr_o, RA);
    chk("rst_pc", pc_o, RA);
    chk("rst_valid", 64'(fetch_valid_o), 64'h0);
    chk("rst_mis", 64'(misalign_o), 64'h0);
    chk("rst_mispc", misalign_pc_o, 64'h0);
    chk("rst_taken", 64'(redir_taken_o), 64'h0);

    rst = 1'b0;
    settle();
    chk("boot_valid", 64'(fetch_valid_o), 64'h0);
    tick();
    chk("run_valid", 64'(fetch_valid_o), 64'h1);
    chk("seq_a0", fetch_addr_o, 64'h8000_0000);
    chk("seq_pc0", pc_o, RA);
    tick();
    chk("seq_a1", fetch_addr_o, 64'h8000_0004);
    chk("seq_pc1", pc_o, 64'h8000_0000);
    tick();
    chk("seq_a2", fetch_addr_o, 64'h8000_0008);
    chk("seq_pc2", pc_o, 64'h8000_0004);

    redir(3'b101, 64'h8000_0100, 64'h0, 64'h8000_0200);
    settle();
    chk("prio_taken", 64'(redir_taken_o), 64'h1);
    chk("prio_valid", 64'(fetch_valid_o), 64'h0);
    tick();
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    settle();
    chk("prio_addr", fetch_addr_o, 64'h8000_0100);
    chk("prio_pc", pc_o, 64'h8000_0004);

    flush_i = 1'b1;
    redir(3'b101, 64'h8000_0100, 64'h0, 64'h8000_0200);
    settle();
    chk("flush_taken", 64'(redir_taken_o), 64'h0);
    chk("flush_valid", 64'(fetch_valid_o), 64'h0);
    tick();
    flush_i = 1'b0;
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    settle();
    chk("flush_addr", fetch_addr_o, RA);

    redir(3'b001, 64'h8000_0010, 64'h0, 64'h0);
    tick();
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    fetch_ready_i = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(fetch_valid_o), 64'h1);
      chk("hold_addr", fetch_addr_o, 64'h8000_0010);
      chk("hold_pc", pc_o, 64'h8000_0004);
      tick();
    end
    fetch_ready_i = 1'b1;
    tick();
    chk("hs_pc", pc_o, 64'h8000_0010);
    chk("hs_addr", fetch_addr_o, 64'h8000_0014);

    stall_i = 1'b1;
    redir(3'b010, 64'h0, 64'h8000_0040, 64'h0);
    settle();
    chk("stall_v0", 64'(fetch_valid_o), 64'h0);
    chk("stall_taken", 64'(redir_taken_o), 64'h2);
    tick();
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    settle();
    chk("stall_v1", 64'(fetch_valid_o), 64'h0);
    chk("stall_addr", fetch_addr_o, 64'h8000_0040);
    tick();
    stall_i = 1'b0;
    settle();
    chk("unstall_v", 64'(fetch_valid_o), 64'h1);
    chk("unstall_addr", fetch_addr_o, 64'h8000_0040);
    chk("unstall_pc", pc_o, 64'h8000_0010);

    redir(3'b010, 64'h0, 64'h8000_0042, 64'h0);
    settle();
    chk("mis_taken", 64'(redir_taken_o), 64'h2);
    tick();
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    settle();
    chk("mis_pulse", 64'(misalign_o), 64'h1);
    chk("mis_pc", misalign_pc_o, 64'h8000_0042);
    chk("mis_addr", fetch_addr_o, 64'h8000_0040);
    tick();
    chk("mis_end", 64'(misalign_o), 64'h0);
    chk("mis_hold", misalign_pc_o, 64'h8000_0042);
    chk("mis_next", fetch_addr_o, 64'h8000_0044);
    chk("mis_pc_o", pc_o, 64'h8000_0040);

    redir(3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0);
    tick();
    redir(3'b000, 64'h0, 64'h0, 64'h0);
    settle();
    chk("wrap_top", fetch_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_addr", fetch_addr_o, 64'h0);
    chk("wrap_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);

    chk("pend_valid", 64'(fetch_valid_o), 64'h1);
    rst = 1'b1;
    tick();
    chk("mrst_addr", fetch_addr_o, RA);
    chk("mrst_pc", pc_o, RA);
    chk("mrst_valid", 64'(fetch_valid_o), 64'h0);
    rst = 1'b0;
    settle();
    chk("mrst_boot", 64'(fetch_valid_o), 64'h0);
    tick();
    chk("mrst_run", 64'(fetch_valid_o), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
